mips_axi_lite_master: RTL and testbench

AXI4-Lite initiator that lets the MIPS core reach memory or peripherals across an AXI4-Lite fabric. It is the master-side counterpart of the platform's AXI-Lite slave interface. It accepts one CPU data access at a time (MemRead / MemWrite, held until acknowledged) and runs the matching AR/R or AW/W/B transaction. It returns read data, completion and error status to the core, and sits between `mips_cpu` and the AXI-Lite interconnect.

---
 rtl/mips_axi_lite_master.sv | 211 +++++++++++++++++++++
 tb/tb_mips_axi_lite_master.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_axi_lite_master.sv
`timescale 1ns/1ps
// mips_axi_lite_master
// AXI4-Lite initiator for the MIPS core data port. It takes one CPU access at
// a time (MemRead / MemWrite held until Mem_done) and runs the matching AR/R
// or AW/W/B transaction. Read data, a completion pulse and an error flag are
// returned to the core.
//
// Ports
//   clk, rst                 core clock, synchronous active-high reset
//   Address, Write_data,     CPU request; sampled when the request is accepted
//   Write_strb
//   MemRead, MemWrite        request strobes; MemWrite wins if both are high
//   Read_data                last completed read data (held)
//   Mem_done, Mem_err        one-cycle completion pulse and its error flag
//   Busy                     high whenever a transaction is in flight
//   m_axi_*                  AXI4-Lite master channels AR, R, AW, W, B
//
// Every output is a flop, so there is no combinational path from any AXI
// input to any output, and no valid depends on a ready in the same cycle.
module mips_axi_lite_master #(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           Address,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [31:0]           Write_data,
  input  logic [3:0]            Write_strb,
  output logic [31:0]           Read_data,
  output logic                  Mem_done,
  output logic                  Mem_err,
  output logic                  Busy,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [31:0]           m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ADDR,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_RESP
  } state_t;

  state_t                r_state, w_state_nxt;

  logic [31:0]           r_read_data, w_read_data_nxt;
  logic                  r_mem_done,  w_mem_done_nxt;
  logic                  r_mem_err,   w_mem_err_nxt;
  logic [ADDR_WIDTH-1:0] r_araddr,    w_araddr_nxt;
  logic                  r_arvalid,   w_arvalid_nxt;
  logic                  r_rready,    w_rready_nxt;
  logic [ADDR_WIDTH-1:0] r_awaddr,    w_awaddr_nxt;
  logic                  r_awvalid,   w_awvalid_nxt;
  logic [31:0]           r_wdata,     w_wdata_nxt;
  logic [3:0]            r_wstrb,     w_wstrb_nxt;
  logic                  r_wvalid,    w_wvalid_nxt;
  logic                  r_bready,    w_bready_nxt;

  // Word-aligned AXI address; the byte offset and upper CPU bits are dropped.
  logic [ADDR_WIDTH-1:0] w_addr_aligned;
  logic                  w_unused_addr;
  logic                  w_aw_done;
  logic                  w_w_done;

  assign w_addr_aligned = {Address[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused_addr  = ^{Address[31:ADDR_WIDTH], Address[1:0]};

  // A channel counts as finished once its valid has dropped or is being
  // accepted this cycle; AW and W may complete in either order.
  assign w_aw_done = !r_awvalid || m_axi_awready;
  assign w_w_done  = !r_wvalid  || m_axi_wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_read_data <= '0;
      r_mem_done  <= 1'b0;
      r_mem_err   <= 1'b0;
      r_araddr    <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awaddr    <= '0;
      r_awvalid   <= 1'b0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_read_data <= w_read_data_nxt;
      r_mem_done  <= w_mem_done_nxt;
      r_mem_err   <= w_mem_err_nxt;
      r_araddr    <= w_araddr_nxt;
      r_arvalid   <= w_arvalid_nxt;
      r_rready    <= w_rready_nxt;
      r_awaddr    <= w_awaddr_nxt;
      r_awvalid   <= w_awvalid_nxt;
      r_wdata     <= w_wdata_nxt;
      r_wstrb     <= w_wstrb_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_bready    <= w_bready_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_read_data_nxt = r_read_data;
    w_mem_done_nxt  = 1'b0;
    w_mem_err_nxt   = 1'b0;
    w_araddr_nxt    = r_araddr;
    w_arvalid_nxt   = r_arvalid;
    w_rready_nxt    = r_rready;
    w_awaddr_nxt    = r_awaddr;
    w_awvalid_nxt   = r_awvalid;
    w_wdata_nxt     = r_wdata;
    w_wstrb_nxt     = r_wstrb;
    w_wvalid_nxt    = r_wvalid;
    w_bready_nxt    = r_bready;

    unique case (r_state)
      S_IDLE: begin
        // While Mem_done is high the CPU is still holding the request it is
        // about to drop, so nothing is accepted in that cycle.
        if (!r_mem_done) begin
          if (MemWrite) begin
            w_awaddr_nxt  = w_addr_aligned;
            w_wdata_nxt   = Write_data;
            w_wstrb_nxt   = Write_strb;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = S_WR_REQ;
          end else if (MemRead) begin
            w_araddr_nxt  = w_addr_aligned;
            w_arvalid_nxt = 1'b1;
            w_state_nxt   = S_RD_ADDR;
          end
        end
      end

      S_RD_ADDR: begin
        if (m_axi_arready) begin
          w_arvalid_nxt = 1'b0;
          w_rready_nxt  = 1'b1;
          w_state_nxt   = S_RD_DATA;
        end
      end

      S_RD_DATA: begin
        if (m_axi_rvalid) begin
          w_read_data_nxt = m_axi_rdata;
          w_rready_nxt    = 1'b0;
          w_mem_done_nxt  = 1'b1;
          w_mem_err_nxt   = (m_axi_rresp != 2'b00);
          w_state_nxt     = S_IDLE;
        end
      end

      S_WR_REQ: begin
        if (m_axi_awready) w_awvalid_nxt = 1'b0;
        if (m_axi_wready)  w_wvalid_nxt  = 1'b0;
        if (w_aw_done && w_w_done) begin
          w_bready_nxt = 1'b1;
          w_state_nxt  = S_WR_RESP;
        end
      end

      S_WR_RESP: begin
        if (m_axi_bvalid) begin
          w_bready_nxt   = 1'b0;
          w_mem_done_nxt = 1'b1;
          w_mem_err_nxt  = (m_axi_bresp != 2'b00);
          w_state_nxt    = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign Read_data     = r_read_data;
  assign Mem_done      = r_mem_done;
  assign Mem_err       = r_mem_err;
  assign Busy          = (r_state != S_IDLE);
  assign m_axi_araddr  = r_araddr;
  assign m_axi_arvalid = r_arvalid;
  assign m_axi_rready  = r_rready;
  assign m_axi_awaddr  = r_awaddr;
  assign m_axi_awvalid = r_awvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_bready  = r_bready;

endmodule

// File: tb/tb_mips_axi_lite_master.sv
`timescale 1ns/1ps
// Directed bench for mips_axi_lite_master: a small programmable-delay slave
// is driven from tasks, and every result is compared against hand-computed
// values.
module tb_mips_axi_lite_master;

  localparam int AW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   Address = '0;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [31:0]   Write_data = '0;
  logic [3:0]    Write_strb = '0;
  logic [31:0]   Read_data;
  logic          Mem_done;
  logic          Mem_err;
  logic          Busy;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid;
  logic          m_axi_arready = 1'b0;
  logic [31:0]   m_axi_rdata = '0;
  logic [1:0]    m_axi_rresp = '0;
  logic          m_axi_rvalid = 1'b0;
  logic          m_axi_rready;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid;
  logic          m_axi_awready = 1'b0;
  logic [31:0]   m_axi_wdata;
  logic [3:0]    m_axi_wstrb;
  logic          m_axi_wvalid;
  logic          m_axi_wready = 1'b0;
  logic [1:0]    m_axi_bresp = '0;
  logic          m_axi_bvalid = 1'b0;
  logic          m_axi_bready;

  int n_checks = 0;
  int n_fails  = 0;

  mips_axi_lite_master #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .Address(Address), .MemRead(MemRead), .MemWrite(MemWrite),
    .Write_data(Write_data), .Write_strb(Write_strb),
    .Read_data(Read_data), .Mem_done(Mem_done), .Mem_err(Mem_err), .Busy(Busy),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic slave_idle();
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rresp = 2'b00;
    m_axi_awready = 1'b0; m_axi_wready = 1'b0;
    m_axi_bvalid  = 1'b0; m_axi_bresp = 2'b00;
  endtask

  // Check that no valid/ready or pulse is active and the block is idle.
  task automatic check_quiet(input string tag);
    check_eq({tag, "_ctl"},
             {25'd0, m_axi_arvalid, m_axi_rready, m_axi_awvalid, m_axi_wvalid,
              m_axi_bready, Mem_done, Busy}, 32'd0);
  endtask

  // Called in the request cycle C0. Returns in the Mem_done cycle with the
  // request dropped; lat is the number of cycles from C0 to Mem_done.
  task automatic do_read(input logic [31:0] addr, input logic [AW-1:0] exp_addr,
                         input int ar_wait, input int r_wait,
                         input logic [31:0] rdata, input logic [1:0] rresp,
                         output int lat);
    int ar_cnt = 0;
    int r_cnt  = 0;
    MemRead = 1'b1;
    Address = addr;
    lat = 0;
    while (!Mem_done && lat < 60) begin
      m_axi_arready = m_axi_arvalid && (ar_cnt >= ar_wait);
      m_axi_rvalid  = m_axi_rready  && (r_cnt  >= r_wait);
      m_axi_rdata   = m_axi_rvalid ? rdata : 32'hBAD0_BAD0;
      m_axi_rresp   = rresp;
      if (m_axi_arvalid) begin
        ar_cnt++;
        check_eq("araddr", {18'd0, m_axi_araddr}, {18'd0, exp_addr});
      end
      if (m_axi_rready) r_cnt++;
      check_eq("no_aw_during_rd", {31'd0, m_axi_awvalid}, 32'd0);
      tick();
      lat++;
    end
    check_eq("rd_done_seen", {31'd0, Mem_done}, 32'd1);
    MemRead = 1'b0;
    slave_idle();
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [AW-1:0] exp_addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input int aw_wait, input int w_wait, input int b_wait,
                          input logic [1:0] bresp,
                          output int lat, output int aw_hi, output int w_hi,
                          output int b_first);
    int aw_cnt = 0;
    int w_cnt  = 0;
    int b_cnt  = 0;
    MemWrite = 1'b1;
    Address = addr; Write_data = data; Write_strb = strb;
    lat = 0; aw_hi = 0; w_hi = 0; b_first = -1;
    while (!Mem_done && lat < 60) begin
      m_axi_awready = m_axi_awvalid && (aw_cnt >= aw_wait);
      m_axi_wready  = m_axi_wvalid  && (w_cnt  >= w_wait);
      m_axi_bvalid  = m_axi_bready  && (b_cnt  >= b_wait);
      m_axi_bresp   = bresp;
      if (m_axi_awvalid) begin
        aw_cnt++; aw_hi++;
        if (aw_cnt == 1) check_eq("awaddr", {18'd0, m_axi_awaddr}, {18'd0, exp_addr});
      end
      if (m_axi_wvalid) begin
        w_cnt++; w_hi++;
        if (w_cnt == 1) check_eq("wdata_wstrb", m_axi_wdata ^ {28'd0, m_axi_wstrb},
                                 data ^ {28'd0, strb});
      end
      if (m_axi_bready) begin
        if (b_first < 0) b_first = lat;
        b_cnt++;
      end
      check_eq("no_ar_during_wr", {31'd0, m_axi_arvalid}, 32'd0);
      tick();
      lat++;
    end
    check_eq("wr_done_seen", {31'd0, Mem_done}, 32'd1);
    MemWrite = 1'b0;
    slave_idle();
  endtask

  initial begin
    int lat, aw_hi, w_hi, b_first;

    // Reset state
    repeat (3) tick();
    check_quiet("rst_hold");
    rst = 1'b0;
    tick();
    check_quiet("rst_state");
    check_eq("rst_rdata", Read_data, 32'd0);
    check_eq("rst_err", {31'd0, Mem_err}, 32'd0);

    // Read, zero-wait
    do_read(32'h0000_0124, 14'h124, 0, 0, 32'hDEAD_BEEF, 2'b00, lat);
    check_eq("rd0_lat", lat, 3);
    check_eq("rd0_data", Read_data, 32'hDEAD_BEEF);
    check_eq("rd0_err", {31'd0, Mem_err}, 32'd0);
    tick();
    check_quiet("rd0_after");
    check_eq("rd0_data_held", Read_data, 32'hDEAD_BEEF);

    // Write, zero-wait
    do_write(32'h0000_0010, 14'h010, 32'hA5A5_0001, 4'hF, 0, 0, 0, 2'b00,
             lat, aw_hi, w_hi, b_first);
    check_eq("wr0_lat", lat, 3);
    check_eq("wr0_bfirst", b_first, 2);
    tick();

    // Write with skewed handshakes: awready at C1, wready at C4
    do_write(32'h0000_0083, 14'h080, 32'h1234_5678, 4'b0011, 0, 3, 0, 2'b00,
             lat, aw_hi, w_hi, b_first);
    check_eq("skew_aw_cycles", aw_hi, 1);
    check_eq("skew_w_cycles", w_hi, 4);
    check_eq("skew_bfirst", b_first, 5);
    check_eq("skew_lat", lat, 6);
    check_eq("skew_err", {31'd0, Mem_err}, 32'd0);
    tick();

    // Stalled read: arready 5 cycles late, rvalid 3 cycles late
    do_read(32'h0000_3FFC, 14'h3FFC, 5, 3, 32'h0BAD_CAFE, 2'b00, lat);
    check_eq("stall_lat", lat, 11);
    check_eq("stall_data", Read_data, 32'h0BAD_CAFE);
    tick();

    // Error responses
    do_write(32'h0000_0200, 14'h200, 32'h0000_00FF, 4'b0001, 1, 0, 2, 2'b10,
             lat, aw_hi, w_hi, b_first);
    check_eq("bresp_err", {31'd0, Mem_err}, 32'd1);
    check_eq("bresp_lat", lat, 6);
    tick();
    check_eq("err_pulse_clear", {30'd0, Mem_err, Mem_done}, 32'd0);
    do_read(32'h0000_0204, 14'h204, 0, 0, 32'hCAFE_F00D, 2'b11, lat);
    check_eq("rresp_err", {31'd0, Mem_err}, 32'd1);
    check_eq("rresp_data", Read_data, 32'hCAFE_F00D);
    tick();

    // Simultaneous request: write wins, then back-to-back read
    MemRead = 1'b1;
    Address = 32'h0000_0040;
    do_write(32'h0000_0040, 14'h040, 32'h5555_AAAA, 4'b1100, 0, 0, 0, 2'b00,
             lat, aw_hi, w_hi, b_first);
    check_eq("both_lat", lat, 3);
    // Read request stays up; it must not be taken in the Mem_done cycle.
    MemRead = 1'b1;
    Address = 32'h0000_0044;
    check_eq("b2b_no_ar_at_done", {31'd0, m_axi_arvalid}, 32'd0);
    tick();
    check_eq("b2b_no_ar_c0", {31'd0, m_axi_arvalid}, 32'd0);
    do_read(32'h0000_0044, 14'h044, 0, 0, 32'h1111_2222, 2'b00, lat);
    check_eq("b2b_lat", lat, 3);
    check_eq("b2b_data", Read_data, 32'h1111_2222);
    tick();

    // Reset while in RD_DATA
    MemRead = 1'b1;
    Address = 32'h0000_0100;
    m_axi_arready = 1'b1;
    tick();
    tick();
    check_eq("rst_rd_in_rdata", {31'd0, m_axi_rready}, 32'd1);
    MemRead = 1'b0;
    slave_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("rst_rd");
    repeat (3) tick();
    check_quiet("rst_rd_nodone");
    do_read(32'h0000_0108, 14'h108, 1, 1, 32'h7777_8888, 2'b00, lat);
    check_eq("rst_rd_next_lat", lat, 5);
    check_eq("rst_rd_next_data", Read_data, 32'h7777_8888);
    tick();

    // Reset while in WR_REQ
    MemWrite = 1'b1;
    Address = 32'h0000_0300; Write_data = 32'hFFFF_0000; Write_strb = 4'hF;
    tick();
    check_eq("rst_wr_in_req", {30'd0, m_axi_awvalid, m_axi_wvalid}, 32'd3);
    MemWrite = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("rst_wr");
    repeat (3) tick();
    check_quiet("rst_wr_nodone");
    do_write(32'h0000_0304, 14'h304, 32'h0F0F_0F0F, 4'b1010, 0, 0, 1, 2'b00,
             lat, aw_hi, w_hi, b_first);
    check_eq("rst_wr_next_lat", lat, 4);
    check_eq("rst_wr_next_err", {31'd0, Mem_err}, 32'd0);
    tick();
    check_quiet("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
